// File: rtl/data_stack_mem_responder.sv
// rtl/data_stack_mem_responder.sv - memory-stage responder: data/stack RAM, stack pointer, split 32-bit stack ops
module data_stack_mem_responder #(
    parameter int                ADDR_W  = 12,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic                  stall,
    output logic [ADDR_W-1:0]     sp
);
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_PUSH16 = 3'd3;
    localparam logic [2:0] OP_POP16  = 3'd4;
    localparam logic [2:0] OP_PUSH32 = 3'd5;
    localparam logic [2:0] OP_POP32  = 3'd6;

    typedef enum logic [1:0] {IDLE, SECOND, RSP} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   sp_next, sp_inc, sp_dec;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   whi_q, hi_q, rd_q;
    logic                accept, hi_load;
    logic                mem_we, mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

    // Stack grows down: push writes at sp then decrements, pop pre-increments then reads.
    assign sp_inc = sp + ADDR_W'(1);
    assign sp_dec = sp - ADDR_W'(1);

    always_comb begin
        state_next = state;
        sp_next    = sp;
        accept     = 1'b0;
        hi_load    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = sp;
        mem_wdata  = req_wdata[DATA_W-1:0];
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = RSP;
                    case (req_op)
                        OP_LOAD: begin
                            mem_re   = 1'b1;
                            mem_addr = req_addr;
                        end
                        OP_STORE: begin
                            mem_we   = 1'b1;
                            mem_addr = req_addr;
                        end
                        OP_PUSH16, OP_PUSH32: begin
                            mem_we  = 1'b1;
                            sp_next = sp_dec;
                            if (req_op == OP_PUSH32) state_next = SECOND;
                        end
                        OP_POP16, OP_POP32: begin
                            mem_re   = 1'b1;
                            mem_addr = sp_inc;
                            sp_next  = sp_inc;
                            if (req_op == OP_POP32) state_next = SECOND;
                        end
                        default: ;
                    endcase
                end
            end
            SECOND: begin
                state_next = RSP;
                if (op_q == OP_PUSH32) begin
                    mem_we    = 1'b1;
                    mem_wdata = whi_q;
                    sp_next   = sp_dec;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = sp_inc;
                    sp_next  = sp_inc;
                    hi_load  = 1'b1;
                end
            end
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sp    <= SP_INIT;
            op_q  <= 3'd0;
            whi_q <= '0;
            hi_q  <= '0;
        end else begin
            state <= state_next;
            sp    <= sp_next;
            if (accept) begin
                op_q  <= req_op;
                whi_q <= req_wdata[2*DATA_W-1:DATA_W];
            end
            if (hi_load) hi_q <= rd_q;
        end
    end

    // RAM contents survive reset; the read register feeds the response.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_addr];
    end

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);
    assign rsp_valid = (state == RSP);

    always_comb begin
        rsp_rdata = '0;
        if (state == RSP) begin
            case (op_q)
                OP_LOAD, OP_POP16: rsp_rdata = {{DATA_W{1'b0}}, rd_q};
                OP_POP32:          rsp_rdata = {hi_q, rd_q};
                default:           rsp_rdata = '0;
            endcase
        end
    end
endmodule
